// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the multi-lane Gray/binary converter.
package gray_conv_pkg;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } mode_e;

    // Bits of the gray2bin prefix chain resolved per pipeline stage.
    function automatic int unsigned chunk_bits(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : (width + stages - 1) / stages;
    endfunction

    function automatic logic [63:0] bin2gray_f(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [63:0] gray2bin_f(input logic [63:0] g);
        logic [63:0] b;
        b = g;
        for (int unsigned i = 1; i < 64; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One pipeline register stage of the converter: resolves one chunk of the
// gray2bin chain for every lane; stage 0 also performs bin2gray outright.
module gray_conv_stage
    import gray_conv_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned STAGE_IDX = 0,
    parameter int unsigned CHUNK     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  mode_e                  in_mode_i,
    input  logic [LANES*WIDTH-1:0] in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output mode_e                  out_mode_o,
    output logic [LANES*WIDTH-1:0] out_data_o
);

    localparam bit          RESOLVES = (STAGE_IDX * CHUNK) < WIDTH;
    localparam int unsigned HI       = RESOLVES ? (WIDTH - 1 - STAGE_IDX * CHUNK) : 0;
    localparam int unsigned LO       = (HI + 1 > CHUNK) ? (HI + 1 - CHUNK) : 0;

    logic [LANES*WIDTH-1:0] nxt_data;

    // Partial word: bits above this stage's chunk are already binary, bits
    // below are still gray, so the lowest resolved bit rides in the word.
    always_comb begin
        nxt_data = in_data_i;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (STAGE_IDX == 0 && in_mode_i == MODE_B2G) begin
                nxt_data[l*WIDTH +: WIDTH] = in_data_i[l*WIDTH +: WIDTH] ^ (in_data_i[l*WIDTH +: WIDTH] >> 1);
            end else if (RESOLVES && in_mode_i == MODE_G2B) begin
                for (int unsigned k = 1; k < WIDTH; k++) begin
                    if ((WIDTH - 1 - k) <= HI && (WIDTH - 1 - k) >= LO) begin
                        nxt_data[l*WIDTH + WIDTH - 1 - k] = in_data_i[l*WIDTH + WIDTH - 1 - k]
                                                          ^ nxt_data[l*WIDTH + WIDTH - k];
                    end
                end
            end
        end
    end

    assign in_ready_o = !out_valid_o || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            out_mode_o  <= MODE_B2G;
            out_data_o  <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (in_ready_o) begin
            out_valid_o <= in_valid_i;
            if (in_valid_i) begin
                out_mode_o <= in_mode_i;
                out_data_o <= nxt_data;
            end
        end
    end

endmodule

// File: rtl/gray_conv_pipe.sv
// Multi-lane pipelined Gray/binary converter with run-time direction select
// and valid/ready flow control; STAGES=0 yields a purely combinational path.
module gray_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   mode_i,
    input  logic [LANES-1:0]       lane_en_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*WIDTH-1:0] data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   mode_o,
    output logic [LANES*WIDTH-1:0] data_o
);

    logic [LANES*WIDTH-1:0] masked;

    // Disabled lanes are zeroed on entry; zero converts to zero both ways.
    always_comb begin
        masked = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_en_i[l]) masked[l*WIDTH +: WIDTH] = data_i[l*WIDTH +: WIDTH];
        end
    end

    generate
        if (STAGES == 0) begin : g_comb
            always_comb begin
                logic [WIDTH-1:0] w;
                logic [WIDTH-1:0] r;
                data_o = '0;
                for (int unsigned l = 0; l < LANES; l++) begin
                    w = masked[l*WIDTH +: WIDTH];
                    r = '0;
                    if (mode_i) begin
                        r[WIDTH-1] = w[WIDTH-1];
                        for (int unsigned k = 1; k < WIDTH; k++) begin
                            r[WIDTH-1-k] = w[WIDTH-1-k] ^ r[WIDTH-k];
                        end
                    end else begin
                        r = w ^ (w >> 1);
                    end
                    if (in_valid_i) data_o[l*WIDTH +: WIDTH] = r;
                end
            end

            assign out_valid_o = in_valid_i;
            assign mode_o      = mode_i;
            assign in_ready_o  = out_ready_i && !flush_i && rst_n_i;
        end else begin : g_pipe
            localparam int unsigned CHUNK = chunk_bits(WIDTH, STAGES);

            logic [STAGES:0]        stg_valid;
            logic [STAGES:0]        stg_ready;
            mode_e                  stg_mode [STAGES+1];
            logic [LANES*WIDTH-1:0] stg_data [STAGES+1];

            assign stg_valid[0]      = in_valid_i;
            assign stg_mode[0]       = mode_e'(mode_i);
            assign stg_data[0]       = masked;
            assign stg_ready[STAGES] = out_ready_i;

            for (genvar s = 0; s < STAGES; s++) begin : g_stage
                gray_conv_stage #(
                    .WIDTH    (WIDTH),
                    .LANES    (LANES),
                    .STAGE_IDX(s),
                    .CHUNK    (CHUNK)
                ) u_stage (
                    .clk_i      (clk_i),
                    .rst_n_i    (rst_n_i),
                    .flush_i    (flush_i),
                    .in_valid_i (stg_valid[s]),
                    .in_ready_o (stg_ready[s]),
                    .in_mode_i  (stg_mode[s]),
                    .in_data_i  (stg_data[s]),
                    .out_valid_o(stg_valid[s+1]),
                    .out_ready_i(stg_ready[s+1]),
                    .out_mode_o (stg_mode[s+1]),
                    .out_data_o (stg_data[s+1])
                );
            end

            assign in_ready_o  = stg_ready[0] && !flush_i && rst_n_i;
            assign out_valid_o = stg_valid[STAGES];
            assign mode_o      = stg_mode[STAGES];
            assign data_o      = stg_data[STAGES];
        end
    endgenerate

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Self-checking bench for gray_conv_pipe: vector table, backpressure stream,
// flush/reset corner cases and a multi-configuration round-trip sweep.
module tb_gray_conv_pipe;
    import gray_conv_pkg::*;

    localparam int unsigned W    = 8;
    localparam int unsigned L    = 4;
    localparam int unsigned S    = 2;
    localparam int unsigned NCFG = 9;
    localparam int unsigned NSW  = 150;

    function automatic int unsigned sw_w(input int unsigned c);
        case (c)
            0, 1, 2: return 2;
            3, 4:    return 8;
            5, 6:    return 13;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned sw_s(input int unsigned c);
        case (c)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 1;
            4: return 8;
            5: return 3;
            6: return 13;
            7: return 0;
            default: return 32;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, flush, mode, in_valid, in_ready, out_valid, out_ready, mode_out;
    logic [L-1:0]     lane_en;
    logic [L*W-1:0]   din, dout;

    gray_conv_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .mode_i(mode), .lane_en_i(lane_en),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .data_i(din), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .mode_o(mode_out), .data_o(dout)
    );

    logic [NCFG-1:0]       sw_vin, sw_mode, sw_vout, sw_rdy, sw_mout;
    logic [NCFG-1:0][31:0] sw_din, sw_dout;

    generate
        for (genvar c = 0; c < NCFG; c++) begin : g_sw
            localparam int unsigned CW = sw_w(c);
            logic [CW-1:0] dout_c;
            gray_conv_pipe #(.WIDTH(CW), .LANES(1), .STAGES(sw_s(c))) u_dut (
                .clk_i(clk), .rst_n_i(rst_n), .flush_i(1'b0), .mode_i(sw_mode[c]), .lane_en_i(1'b1),
                .in_valid_i(sw_vin[c]), .in_ready_o(sw_rdy[c]), .data_i(sw_din[c][CW-1:0]),
                .out_valid_o(sw_vout[c]), .out_ready_i(1'b1), .mode_o(sw_mout[c]), .data_o(dout_c)
            );
            assign sw_dout[c] = 32'(dout_c);
        end
    endgenerate

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: gray->binary bit i is the parity of all gray bits at or above i.
    function automatic logic [31:0] model_word(input logic m, input logic [3:0] en, input logic [31:0] d);
        logic [31:0] r;
        logic [7:0]  v, o;
        r = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            v = d[k*8 +: 8];
            o = '0;
            if (m) for (int unsigned i = 0; i < 8; i++) o[i] = ^(v >> i);
            else   o = v ^ (v >> 1);
            if (en[k]) r[k*8 +: 8] = o;
        end
        return r;
    endfunction

    task automatic send_word(input string name, input logic m, input logic [3:0] en,
                             input logic [31:0] d, input logic [31:0] exp);
        int lat;
        @(posedge clk); #1;
        mode = m; lane_en = en; din = d; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, S);
        check({name, "_data"}, dout, exp);
        check({name, "_mode"}, mode_out, m);
    endtask

    typedef struct {
        logic        m;
        logic [3:0]  en;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        m;
        logic [31:0] d;
    } exp_t;

    vec_t        vecs [5];
    exp_t        q [$];
    exp_t        e;
    logic [31:0] hist_e [NCFG][NSW];
    logic        hist_m [NCFG][NSW];

    initial begin
        rst_n = 1'b0; flush = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        lane_en = '1; din = '0;
        sw_vin = '0; sw_mode = '0; sw_din = '0;

        vecs[0] = '{1'b1, 4'hF, 32'h80C00100, 32'hFF800100};
        vecs[1] = '{1'b0, 4'b1011, 32'hFF80053C, 32'h80000722};
        vecs[2] = '{1'b0, 4'hF, 32'h00FF1234, 32'h00801B2E};
        vecs[3] = '{1'b1, 4'hF, 32'hFFFFFFFF, 32'hAAAAAAAA};
        vecs[4] = '{1'b1, 4'b0110, 32'h12345678, 32'h00276400};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data", dout, 0);
        check("rst_mode", mode_out, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) send_word($sformatf("vec%0d", i), vecs[i].m, vecs[i].en, vecs[i].d, vecs[i].exp);

        // Backpressure stream
        begin
            int          sent, got, occ;
            logic        prev_stall, prev_m, m;
            logic [31:0] prev_d, x;
            logic [3:0]  en;
            sent = 0; got = 0; occ = 0; prev_stall = 1'b0; prev_m = 1'b0; prev_d = '0;
            for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
                @(posedge clk); #1;
                if (prev_stall) begin
                    check("bp_hold_valid", out_valid, 1);
                    check("bp_hold_data", dout, prev_d);
                    check("bp_hold_mode", mode_out, prev_m);
                end
                in_valid = (sent < 10);
                m  = 1'($urandom_range(0, 1));
                x  = $urandom;
                en = 4'($urandom);
                mode = m; din = x; lane_en = en;
                out_ready = (cyc >= 3 && cyc <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
                #1;
                check("bp_in_ready", in_ready, !(occ == 2 && !out_ready));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("bp_spurious_output", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("bp_data", dout, e.d);
                        check("bp_mode", mode_out, e.m);
                    end
                    got++;
                    occ--;
                end
                if (in_valid && in_ready) begin
                    q.push_back('{m, model_word(m, en, x)});
                    sent++;
                    occ++;
                end
                prev_stall = out_valid && !out_ready;
                prev_d = dout;
                prev_m = mode_out;
            end
            in_valid = 1'b0;
            check("bp_delivered", got, 10);
            check("bp_queue_empty", q.size(), 0);
        end

        // Flush with two words in flight and input pending
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; lane_en = '1; din = 32'h11111111;
        @(posedge clk); #1;
        din = 32'h22222222;
        @(posedge clk); #1;
        check("fl_pre_valid", out_valid, 1);
        flush = 1'b1; din = 32'h33333333;
        #1;
        check("fl_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_out_valid", out_valid, 0);
        check("fl_data_kept", dout, 32'h19191919);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("fl_no_output", out_valid, 0);
        end
        send_word("fl_after", 1'b0, 4'hF, 32'h44444444, 32'h66666666);

        // Reset mid-flight
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; mode = 1'b1; lane_en = '1; din = 32'h55555555;
        @(posedge clk); #1;
        din = 32'h66666666;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rs_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("rs_out_valid", out_valid, 0);
        check("rs_data", dout, 0);
        check("rs_mode", mode_out, 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rs_no_output", out_valid, 0);
        end
        send_word("rs_after", 1'b1, 4'hF, 32'h80C00100, 32'hFF800100);

        // Parameter sweep: random round trips, latency must equal STAGES
        for (int t = 0; t < int'(NSW) + 34; t++) begin
            @(posedge clk); #1;
            for (int unsigned c = 0; c < NCFG; c++) begin
                logic [63:0] mk, x64, g64;
                logic        m;
                if (t < int'(NSW)) begin
                    mk  = (64'd1 << sw_w(c)) - 64'd1;
                    x64 = {32'h0, $urandom} & mk;
                    g64 = bin2gray_f(x64);
                    m   = 1'($urandom_range(0, 1));
                    hist_m[c][t] = m;
                    hist_e[c][t] = m ? x64[31:0] : g64[31:0];
                    sw_vin[c]  = 1'b1;
                    sw_mode[c] = m;
                    sw_din[c]  = m ? g64[31:0] : x64[31:0];
                end else begin
                    sw_vin[c] = 1'b0;
                end
            end
            #1;
            for (int unsigned c = 0; c < NCFG; c++) begin
                int   u;
                logic ev;
                u  = t - int'(sw_s(c));
                ev = (u >= 0 && u < int'(NSW));
                check($sformatf("sw%0d_valid", c), sw_vout[c], ev);
                if (t < int'(NSW)) check($sformatf("sw%0d_ready", c), sw_rdy[c], 1);
                if (ev) begin
                    check($sformatf("sw%0d_data", c), sw_dout[c], hist_e[c][u]);
                    check($sformatf("sw%0d_mode", c), sw_mout[c], hist_m[c][u]);
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
